// File: rtl/pktbuf_pkg.sv
// Shared types and sizing helpers for the packet-buffer scheduler.
package pktbuf_pkg;

  localparam int unsigned N_BUFS_DEFAULT = 3;
  localparam int unsigned CNT_W_DEFAULT  = 32;

  // Buffer-index width: clog2 of the buffer count, never below one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned SEL_W_DEFAULT = sel_w(N_BUFS_DEFAULT);

  typedef logic [SEL_W_DEFAULT-1:0] buf_idx_t;

  typedef enum logic {
    CPU_IDLE = 1'b0,
    CPU_BUSY = 1'b1
  } cpu_state_t;

endpackage

// File: rtl/idx_fifo.sv
// Ring-buffer FIFO of buffer indices with two ordered push ports (a before b).
module idx_fifo
  import pktbuf_pkg::*;
#(
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned W         = 2,
  parameter bit          INIT_FULL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_a,
  input  logic [W-1:0]               data_a,
  input  logic                       push_b,
  input  logic [W-1:0]               data_b,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = sel_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;

  logic [PW-1:0] w_wr_b;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic [CW-1:0] w_cnt_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer/count advance; push_b lands in the slot after push_a when both fire.
  always_comb begin
    w_wr_b    = push_a ? ptr_inc(r_wr) : r_wr;
    w_wr_nxt  = push_b ? ptr_inc(w_wr_b) : w_wr_b;
    w_rd_nxt  = pop ? ptr_inc(r_rd) : r_rd;
    w_cnt_nxt = r_cnt + CW'(push_a) + CW'(push_b) - CW'(pop);
  end

  // Storage and pointers; INIT_FULL preloads indices 0..DEPTH-1 in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INIT_FULL ? W'(i) : '0;
      end
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= INIT_FULL ? CW'(DEPTH) : '0;
    end else begin
      if (push_a) r_mem[r_wr] <= data_a;
      if (push_b) r_mem[w_wr_b] <= data_b;
      r_rd  <= w_rd_nxt;
      r_wr  <= w_wr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign head  = r_mem[r_rd];
  assign empty = (r_cnt == '0);
  assign count = r_cnt;

endmodule

// File: rtl/pktbuf_sched.sv
// Rotates packet buffers through snooper -> CPU filter -> forwarder via index queues.
module pktbuf_sched
  import pktbuf_pkg::*;
#(
  parameter int unsigned  N_BUFS = N_BUFS_DEFAULT,
  parameter int unsigned  CNT_W  = CNT_W_DEFAULT,
  localparam int unsigned SEL_W  = sel_w(N_BUFS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready_for_snooper,
  output logic [SEL_W-1:0] snooper_sel,
  input  logic             snooper_done,
  output logic             cpu_start,
  output logic [SEL_W-1:0] cpu_sel,
  output logic             cpu_busy,
  input  logic             cpu_accept,
  input  logic             cpu_reject,
  output logic             ready_for_forwarder,
  output logic [SEL_W-1:0] forwarder_sel,
  input  logic             forwarder_done,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] reject_cnt,
  output logic             proto_err
);

  localparam int unsigned CW = $clog2(N_BUFS + 1);
  localparam int unsigned TW = CW + 2;

  cpu_state_t       r_state;
  cpu_state_t       w_state_nxt;
  logic             r_cpu_start;
  logic [SEL_W-1:0] r_cpu_sel;
  logic [CNT_W-1:0] r_accept_cnt;
  logic [CNT_W-1:0] r_reject_cnt;
  logic             r_proto_err;

  logic             w_start_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_cpu_pop;

  logic [SEL_W-1:0] w_free_head, w_cpu_head, w_fwd_head;
  logic             w_free_empty, w_cpu_empty, w_fwd_empty;
  logic [CW-1:0]    w_free_cnt, w_cpu_cnt, w_fwd_cnt;

  logic w_busy;
  logic w_snp_ok, w_fwd_ok, w_acc_ok, w_rej_ok, w_err;

  assign w_busy = (r_state == CPU_BUSY);

  // Qualify agent events; anything illegal is dropped and flagged.
  always_comb begin
    w_snp_ok = snooper_done && !w_free_empty;
    w_fwd_ok = forwarder_done && !w_fwd_empty;
    w_acc_ok = cpu_accept && !cpu_reject && w_busy;
    w_rej_ok = cpu_reject && !cpu_accept && w_busy;
    w_err    = (snooper_done && w_free_empty) ||
               (forwarder_done && w_fwd_empty) ||
               ((cpu_accept || cpu_reject) && !w_busy) ||
               (cpu_accept && cpu_reject);
  end

  // Free buffers; reject returns ahead of forwarder returns in the same cycle.
  idx_fifo #(.DEPTH(N_BUFS), .W(SEL_W), .INIT_FULL(1'b1)) u_free_q (
    .clk    (clk),
    .rst    (rst),
    .push_a (w_rej_ok),
    .data_a (r_cpu_sel),
    .push_b (w_fwd_ok),
    .data_b (w_fwd_head),
    .pop    (w_snp_ok),
    .head   (w_free_head),
    .empty  (w_free_empty),
    .count  (w_free_cnt)
  );

  // Filled buffers waiting for the CPU.
  idx_fifo #(.DEPTH(N_BUFS), .W(SEL_W), .INIT_FULL(1'b0)) u_cpu_q (
    .clk    (clk),
    .rst    (rst),
    .push_a (w_snp_ok),
    .data_a (w_free_head),
    .push_b (1'b0),
    .data_b ('0),
    .pop    (w_cpu_pop),
    .head   (w_cpu_head),
    .empty  (w_cpu_empty),
    .count  (w_cpu_cnt)
  );

  // Accepted buffers waiting for the forwarder.
  idx_fifo #(.DEPTH(N_BUFS), .W(SEL_W), .INIT_FULL(1'b0)) u_fwd_q (
    .clk    (clk),
    .rst    (rst),
    .push_a (w_acc_ok),
    .data_a (r_cpu_sel),
    .push_b (1'b0),
    .data_b ('0),
    .pop    (w_fwd_ok),
    .head   (w_fwd_head),
    .empty  (w_fwd_empty),
    .count  (w_fwd_cnt)
  );

  // CPU ownership FSM: dispatch when idle, release on a single clean verdict.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_sel_nxt   = r_cpu_sel;
    w_cpu_pop   = 1'b0;
    case (r_state)
      CPU_IDLE: begin
        if (!w_cpu_empty) begin
          w_state_nxt = CPU_BUSY;
          w_start_nxt = 1'b1;
          w_sel_nxt   = w_cpu_head;
          w_cpu_pop   = 1'b1;
        end
      end
      CPU_BUSY: begin
        if (w_acc_ok || w_rej_ok) w_state_nxt = CPU_IDLE;
      end
      default: w_state_nxt = CPU_IDLE;
    endcase
  end

  // CPU state and registered CPU-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CPU_IDLE;
      r_cpu_start <= 1'b0;
      r_cpu_sel   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_start <= w_start_nxt;
      r_cpu_sel   <= w_sel_nxt;
    end
  end

  // Verdict statistics and sticky protocol-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accept_cnt <= '0;
      r_reject_cnt <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_acc_ok) r_accept_cnt <= r_accept_cnt + CNT_W'(1);
      if (w_rej_ok) r_reject_cnt <= r_reject_cnt + CNT_W'(1);
      if (w_err)    r_proto_err  <= 1'b1;
    end
  end

  // Every buffer is owned by exactly one queue or by the CPU.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (TW'(w_free_cnt) + TW'(w_cpu_cnt) + TW'(w_fwd_cnt) + TW'(w_busy) == TW'(N_BUFS));
    end
  end

  assign ready_for_snooper   = !w_free_empty;
  assign snooper_sel         = w_free_head;
  assign cpu_start           = r_cpu_start;
  assign cpu_sel             = r_cpu_sel;
  assign cpu_busy            = w_busy;
  assign ready_for_forwarder = !w_fwd_empty;
  assign forwarder_sel       = w_fwd_head;
  assign accept_cnt          = r_accept_cnt;
  assign reject_cnt          = r_reject_cnt;
  assign proto_err           = r_proto_err;

endmodule

// File: tb/tb_pktbuf_sched.sv
// Bench for pktbuf_sched: directed scenarios plus random traffic against a queue model.
module tb_pktbuf_sched;
  import pktbuf_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 32;

  logic          clk;
  logic          rst;
  logic          ready_for_snooper;
  logic [SW-1:0] snooper_sel;
  logic          snooper_done;
  logic          cpu_start;
  logic [SW-1:0] cpu_sel;
  logic          cpu_busy;
  logic          cpu_accept;
  logic          cpu_reject;
  logic          ready_for_forwarder;
  logic [SW-1:0] forwarder_sel;
  logic          forwarder_done;
  logic [CW-1:0] accept_cnt;
  logic [CW-1:0] reject_cnt;
  logic          proto_err;

  int n_checks;
  int n_fail;

  pktbuf_sched #(.N_BUFS(N), .CNT_W(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ready_for_snooper   (ready_for_snooper),
    .snooper_sel         (snooper_sel),
    .snooper_done        (snooper_done),
    .cpu_start           (cpu_start),
    .cpu_sel             (cpu_sel),
    .cpu_busy            (cpu_busy),
    .cpu_accept          (cpu_accept),
    .cpu_reject          (cpu_reject),
    .ready_for_forwarder (ready_for_forwarder),
    .forwarder_sel       (forwarder_sel),
    .forwarder_done      (forwarder_done),
    .accept_cnt          (accept_cnt),
    .reject_cnt          (reject_cnt),
    .proto_err           (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: buffer ownership as plain queues of indices.
  int          m_free[$];
  int          m_cpu[$];
  int          m_fwd[$];
  bit          m_busy;
  bit          m_start;
  bit          m_err;
  buf_idx_t    m_sel;
  int unsigned m_acc;
  int unsigned m_rej;

  function automatic void model_reset();
    m_free.delete();
    m_cpu.delete();
    m_fwd.delete();
    for (int i = 0; i < int'(N); i++) m_free.push_back(i);
    m_busy = 0; m_start = 0; m_err = 0; m_sel = '0; m_acc = 0; m_rej = 0;
  endfunction

  function automatic void model_step(input bit snp, input bit acc, input bit rej, input bit fwd);
    bit s_ok, f_ok, a_ok, r_ok, disp;
    int f_idx;
    buf_idx_t v_idx;
    s_ok = snp && (m_free.size() > 0);
    f_ok = fwd && (m_fwd.size() > 0);
    a_ok = acc && !rej && m_busy;
    r_ok = rej && !acc && m_busy;
    if ((snp && !s_ok) || (fwd && !f_ok) || ((acc || rej) && !(a_ok || r_ok))) m_err = 1;
    disp    = !m_busy && (m_cpu.size() > 0);
    m_start = disp;
    v_idx   = m_sel;
    f_idx   = 0;
    if (disp) begin
      m_sel  = buf_idx_t'(m_cpu.pop_front());
      m_busy = 1;
    end
    if (s_ok) m_cpu.push_back(m_free.pop_front());
    if (f_ok) f_idx = m_fwd.pop_front();
    if (a_ok) begin m_fwd.push_back(int'(v_idx)); m_acc++; m_busy = 0; end
    if (r_ok) begin m_free.push_back(int'(v_idx)); m_rej++; m_busy = 0; end
    if (f_ok) m_free.push_back(f_idx);
  endfunction

  // One clock of stimulus: inputs held across one active edge, model advanced alongside.
  task automatic cycle(input bit snp, input bit acc, input bit rej, input bit fwd);
    snooper_done   = snp;
    cpu_accept     = acc;
    cpu_reject     = rej;
    forwarder_done = fwd;
    model_step(snp, acc, rej, fwd);
    @(posedge clk);
    #1;
    snooper_done = 0; cpu_accept = 0; cpu_reject = 0; forwarder_done = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    snooper_done = 0; cpu_accept = 0; cpu_reject = 0; forwarder_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ready_for_snooper !== 1'b1) begin n_fail++; $display("FAIL reset_rfs got=%b exp=1", ready_for_snooper); end
    n_checks++; if (snooper_sel !== 2'd0) begin n_fail++; $display("FAIL reset_ssel got=%0d exp=0", snooper_sel); end
    n_checks++; if (ready_for_forwarder !== 1'b0) begin n_fail++; $display("FAIL reset_rff got=%b exp=0", ready_for_forwarder); end
    n_checks++; if (cpu_busy !== 1'b0 || cpu_start !== 1'b0 || cpu_sel !== 2'd0) begin
      n_fail++; $display("FAIL reset_cpu got busy=%b start=%b sel=%0d exp=0/0/0", cpu_busy, cpu_start, cpu_sel); end
    n_checks++; if (proto_err !== 1'b0 || accept_cnt !== 0 || reject_cnt !== 0) begin
      n_fail++; $display("FAIL reset_stat got err=%b acc=%0d rej=%0d exp=0/0/0", proto_err, accept_cnt, reject_cnt); end
  endtask

  task automatic test_single_packet();
    do_reset();
    cycle(1, 0, 0, 0);
    n_checks++; if (snooper_sel !== 2'd1 || cpu_start !== 1'b0) begin
      n_fail++; $display("FAIL single_snoop got ssel=%0d start=%b exp=1/0", snooper_sel, cpu_start); end
    cycle(0, 0, 0, 0);
    n_checks++; if (cpu_start !== 1'b1 || cpu_sel !== 2'd0 || cpu_busy !== 1'b1) begin
      n_fail++; $display("FAIL single_start got start=%b sel=%0d busy=%b exp=1/0/1", cpu_start, cpu_sel, cpu_busy); end
    cycle(0, 0, 0, 0);
    n_checks++; if (cpu_start !== 1'b0 || cpu_busy !== 1'b1) begin
      n_fail++; $display("FAIL single_pulse got start=%b busy=%b exp=0/1", cpu_start, cpu_busy); end
    cycle(0, 1, 0, 0);
    n_checks++; if (ready_for_forwarder !== 1'b1 || forwarder_sel !== 2'd0 || accept_cnt !== 1 || cpu_busy !== 1'b0) begin
      n_fail++; $display("FAIL single_accept got rff=%b fsel=%0d acc=%0d busy=%b exp=1/0/1/0",
                         ready_for_forwarder, forwarder_sel, accept_cnt, cpu_busy); end
    cycle(0, 0, 0, 1);
    n_checks++; if (ready_for_forwarder !== 1'b0 || snooper_sel !== 2'd1) begin
      n_fail++; $display("FAIL single_fwd got rff=%b ssel=%0d exp=0/1", ready_for_forwarder, snooper_sel); end
    cycle(1, 0, 0, 0);
    n_checks++; if (snooper_sel !== 2'd2) begin n_fail++; $display("FAIL single_tail1 got=%0d exp=2", snooper_sel); end
    cycle(1, 0, 0, 0);
    n_checks++; if (snooper_sel !== 2'd0) begin n_fail++; $display("FAIL single_tail2 got=%0d exp=0", snooper_sel); end
  endtask

  task automatic test_fill();
    do_reset();
    repeat (3) cycle(1, 0, 0, 0);
    n_checks++; if (ready_for_snooper !== 1'b0 || cpu_busy !== 1'b1 || cpu_sel !== 2'd0) begin
      n_fail++; $display("FAIL fill_full got rfs=%b busy=%b sel=%0d exp=0/1/0", ready_for_snooper, cpu_busy, cpu_sel); end
    cycle(1, 0, 0, 0);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL fill_err got=%b exp=1", proto_err); end
    n_checks++; if (ready_for_snooper !== 1'b0 || ready_for_forwarder !== 1'b0 || cpu_sel !== 2'd0) begin
      n_fail++; $display("FAIL fill_nochg got rfs=%b rff=%b sel=%0d exp=0/0/0", ready_for_snooper, ready_for_forwarder, cpu_sel); end
  endtask

  task automatic test_order();
    do_reset();
    repeat (3) cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    n_checks++; if (cpu_start !== 1'b1 || cpu_sel !== 2'd1) begin
      n_fail++; $display("FAIL order_disp1 got start=%b sel=%0d exp=1/1", cpu_start, cpu_sel); end
    cycle(0, 1, 0, 0);
    n_checks++; if (forwarder_sel !== 2'd1) begin n_fail++; $display("FAIL order_fsel1 got=%0d exp=1", forwarder_sel); end
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    n_checks++; if (accept_cnt !== 2 || reject_cnt !== 1 || snooper_sel !== 2'd0 || ready_for_snooper !== 1'b1) begin
      n_fail++; $display("FAIL order_cnt got acc=%0d rej=%0d ssel=%0d rfs=%b exp=2/1/0/1",
                         accept_cnt, reject_cnt, snooper_sel, ready_for_snooper); end
    cycle(0, 0, 0, 1);
    n_checks++; if (forwarder_sel !== 2'd2 || ready_for_forwarder !== 1'b1) begin
      n_fail++; $display("FAIL order_fsel2 got fsel=%0d rff=%b exp=2/1", forwarder_sel, ready_for_forwarder); end
  endtask

  task automatic test_dual_push();
    do_reset();
    repeat (3) cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    n_checks++; if (cpu_sel !== 2'd2 || forwarder_sel !== 2'd1) begin
      n_fail++; $display("FAIL dual_setup got sel=%0d fsel=%0d exp=2/1", cpu_sel, forwarder_sel); end
    cycle(0, 0, 1, 1);
    n_checks++; if (cpu_busy !== 1'b0 || ready_for_forwarder !== 1'b0 || reject_cnt !== 2 || proto_err !== 1'b0) begin
      n_fail++; $display("FAIL dual_state got busy=%b rff=%b rej=%0d err=%b exp=0/0/2/0",
                         cpu_busy, ready_for_forwarder, reject_cnt, proto_err); end
    n_checks++; if (snooper_sel !== 2'd0) begin n_fail++; $display("FAIL dual_head got=%0d exp=0", snooper_sel); end
    cycle(1, 0, 0, 0);
    n_checks++; if (snooper_sel !== 2'd2) begin n_fail++; $display("FAIL dual_tail_rej got=%0d exp=2", snooper_sel); end
    cycle(1, 0, 0, 0);
    n_checks++; if (snooper_sel !== 2'd1) begin n_fail++; $display("FAIL dual_tail_fwd got=%0d exp=1", snooper_sel); end
  endtask

  task automatic test_both_verdict_and_reset();
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    n_checks++; if (proto_err !== 1'b1 || cpu_busy !== 1'b1 || accept_cnt !== 0 || reject_cnt !== 0) begin
      n_fail++; $display("FAIL both_verdict got err=%b busy=%b acc=%0d rej=%0d exp=1/1/0/0",
                         proto_err, cpu_busy, accept_cnt, reject_cnt); end
    cycle(0, 1, 0, 0);
    #1;
    rst = 1;
    #2;
    n_checks++; if (cpu_busy !== 1'b0 || cpu_sel !== 2'd0 || cpu_start !== 1'b0 || proto_err !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_cpu got busy=%b sel=%0d start=%b err=%b exp=0/0/0/0",
                         cpu_busy, cpu_sel, cpu_start, proto_err); end
    n_checks++; if (ready_for_snooper !== 1'b1 || snooper_sel !== 2'd0 || ready_for_forwarder !== 1'b0 || accept_cnt !== 0) begin
      n_fail++; $display("FAIL async_rst_q got rfs=%b ssel=%0d rff=%b acc=%0d exp=1/0/0/0",
                         ready_for_snooper, snooper_sel, ready_for_forwarder, accept_cnt); end
  endtask

  task automatic test_random();
    bit snp, acc, rej, fwd;
    int unsigned v;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 400 == 399) do_reset();
      snp = (m_free.size() > 0) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 199) == 0);
      fwd = (m_fwd.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 199) == 0);
      acc = 0; rej = 0;
      if (m_busy) begin
        v = $urandom_range(0, 99);
        acc = (v < 30) || (v == 99);
        rej = (v >= 30 && v < 55) || (v == 99);
      end else if ($urandom_range(0, 199) == 0) begin
        acc = 1;
      end
      cycle(snp, acc, rej, fwd);
      n_checks++; if (ready_for_snooper !== (m_free.size() > 0)) begin
        n_fail++; $display("FAIL rnd_rfs cyc=%0d got=%b exp=%b", cyc, ready_for_snooper, m_free.size() > 0); end
      if (m_free.size() > 0) begin
        n_checks++; if (snooper_sel !== SW'(m_free[0])) begin
          n_fail++; $display("FAIL rnd_ssel cyc=%0d got=%0d exp=%0d", cyc, snooper_sel, m_free[0]); end
      end
      n_checks++; if (cpu_busy !== m_busy || cpu_start !== m_start || cpu_sel !== m_sel) begin
        n_fail++; $display("FAIL rnd_cpu cyc=%0d got busy=%b start=%b sel=%0d exp=%b/%b/%0d",
                           cyc, cpu_busy, cpu_start, cpu_sel, m_busy, m_start, m_sel); end
      n_checks++; if (ready_for_forwarder !== (m_fwd.size() > 0)) begin
        n_fail++; $display("FAIL rnd_rff cyc=%0d got=%b exp=%b", cyc, ready_for_forwarder, m_fwd.size() > 0); end
      if (m_fwd.size() > 0) begin
        n_checks++; if (forwarder_sel !== SW'(m_fwd[0])) begin
          n_fail++; $display("FAIL rnd_fsel cyc=%0d got=%0d exp=%0d", cyc, forwarder_sel, m_fwd[0]); end
      end
      n_checks++; if (accept_cnt !== m_acc || reject_cnt !== m_rej || proto_err !== m_err) begin
        n_fail++; $display("FAIL rnd_stat cyc=%0d got acc=%0d rej=%0d err=%b exp=%0d/%0d/%b",
                           cyc, accept_cnt, reject_cnt, proto_err, m_acc, m_rej, m_err); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1;
    snooper_done = 0; cpu_accept = 0; cpu_reject = 0; forwarder_done = 0;
    model_reset();
    test_reset();
    test_single_packet();
    test_fill();
    test_order();
    test_dual_push();
    test_both_verdict_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
